// File: rtl/scl_phase_gen.sv
// scl_phase_gen: programmable SCL period generator with four phase strobes,
// slave clock-stretch hold with timeout, and a graceful stop at period end.
// Outputs are registered. The registered output value is the decode of the
// next state, so each strobe lines up with the cycle in which the internal
// counter sits on its phase point.
module scl_phase_gen #(
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned DIV_MIN    = 4,
    parameter bit          STRETCH_EN = 1'b1,
    parameter int unsigned TMO_W      = 16,
    parameter int unsigned TMO_MAX    = 50000
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_SCL_en,
    input  logic [CNT_W-1:0] I_div,
    input  logic             I_SCL_in,
    output logic             O_SCL_POS,
    output logic             O_SCL_HIG,
    output logic             O_SCL_NEG,
    output logic             O_SCL_LOW,
    output logic             O_SCL,
    output logic             O_busy,
    output logic             O_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STRETCH = 2'd2
    } state_e;

    // Output vector order: {pos, hig, neg, low, scl, busy, timeout}
    localparam int unsigned OUT_W   = 7;
    localparam logic [OUT_W-1:0] OUT_IDLE = 7'b000_0100;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [OUT_W-1:0]   out_q, out_d;

    logic [CNT_W-1:0]   div_eff;
    logic [CNT_W-1:0]   pt_h;
    logic               tmo_hit;
    logic               stretch_now;

    // Output decode for a given (state, cnt, divider, timeout count, synced SCL)
    function automatic logic [OUT_W-1:0] decode(
        input state_e           st,
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] div,
        input logic [TMO_W-1:0] tmo,
        input logic             scl_s
    );
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] n;
        logic [CNT_W-1:0] l;
        logic             hit;
        logic [OUT_W-1:0] o;
        h   = div >> 2;
        n   = div >> 1;
        l   = n + h;
        hit = (tmo == TMO_W'(TMO_MAX));
        o   = OUT_IDLE;
        case (st)
            ST_RUN: begin
                o[6] = (cnt == '0);
                o[5] = (cnt == h) && (scl_s || !STRETCH_EN);
                o[4] = (cnt == n);
                o[3] = (cnt == l);
                o[2] = (cnt < n);
                o[1] = 1'b1;
            end
            ST_STRETCH: begin
                o[5] = !hit && scl_s;
                o[2] = 1'b1;
                o[1] = 1'b1;
                o[0] = hit;
            end
            default: o = OUT_IDLE;
        endcase
        return o;
    endfunction

    assign div_eff     = (I_div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : I_div;
    assign pt_h        = div_q >> 2;
    assign tmo_hit     = (tmo_q == TMO_W'(TMO_MAX));
    assign stretch_now = STRETCH_EN && (cnt_q == pt_h) && !sync2_q;

    // Next-state, counter, divider latch, timeout count and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        tmo_d   = tmo_q;
        sync1_d = I_SCL_in;
        sync2_d = sync1_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                tmo_d = '0;
                if (I_SCL_en) begin
                    state_d = ST_RUN;
                    div_d   = div_eff;
                end
            end
            ST_RUN: begin
                if (stretch_now) begin
                    state_d = ST_STRETCH;
                    tmo_d   = '0;
                end else if (cnt_q == div_q - CNT_W'(1)) begin
                    cnt_d = '0;
                    if (I_SCL_en) begin
                        div_d = div_eff;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STRETCH: begin
                // Timeout wins over a release seen in the same cycle
                if (tmo_hit) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else if (sync2_q) begin
                    state_d = ST_RUN;
                    cnt_d   = cnt_q + CNT_W'(1);
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                tmo_d   = '0;
            end
        endcase
        // sync2_d is what sync2_q will hold in the cycle being decoded
        out_d = decode(state_d, cnt_d, div_d, tmo_d, sync2_d);
    end

    // State, counters, synchroniser and output registers
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            tmo_q   <= '0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            out_q   <= OUT_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            tmo_q   <= tmo_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            out_q   <= out_d;
        end
    end

    assign {O_SCL_POS, O_SCL_HIG, O_SCL_NEG, O_SCL_LOW, O_SCL, O_busy, O_timeout} = out_q;

endmodule
